conv_dw_sched: RTL and testbench

//   Output-position scheduler for one 3x3 depthwise conv stage (16 channels, 9 taps per channel).

---
 rtl/conv_dw_sched.sv | 136 +++++++++++++
 tb/tb_conv_dw_sched.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_dw_sched.sv
// Output-position scheduler for a 3x3 depthwise conv stage: raster-walks output pixels,
// issues one window per cycle with its tap in-bounds mask, and pairs engine results with write addresses.
module conv_dw_sched #(
    parameter int IMG_H     = 16,
    parameter int IMG_W     = 16,
    parameter int STRIDE    = 1,
    parameter int PAD       = 1,
    parameter int COORD_W   = 8,
    parameter int ADDR_W    = 10,
    parameter int TAG_DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      hold,
    output logic                      eng_valid,
    output logic signed [COORD_W-1:0] win_row,
    output logic signed [COORD_W-1:0] win_col,
    output logic [8:0]                tap_mask,
    input  logic                      eng_ready,
    output logic                      out_wr_en,
    output logic [ADDR_W-1:0]         out_wr_addr,
    output logic                      busy,
    output logic                      done,
    output logic                      err
);

    localparam int OH    = (IMG_H + 2*PAD - 3) / STRIDE + 1;
    localparam int OW    = (IMG_W + 2*PAD - 3) / STRIDE + 1;
    localparam int PTR_W = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
    localparam int CNT_W = $clog2(TAG_DEPTH) + 1;

    localparam logic [COORD_W-1:0] OW_LAST = COORD_W'(OW - 1);
    localparam logic [COORD_W-1:0] OH_LAST = COORD_W'(OH - 1);
    localparam logic [CNT_W-1:0]   DEPTH_C = CNT_W'(TAG_DEPTH);
    localparam logic [CNT_W-1:0]   ONE_C   = CNT_W'(1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t state_q, state_d;

    logic [COORD_W-1:0] ox_q, oy_q;
    logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]   inflight_q;
    logic [ADDR_W-1:0]  tag_mem [TAG_DEPTH];

    logic                      issue, pop, last_pos;
    logic signed [COORD_W-1:0] row_d, col_d;
    logic [8:0]                mask_d;
    logic [ADDR_W-1:0]         addr_d;
    int                        row_i, col_i;

    assign issue    = (state_q == S_RUN) && !hold && (inflight_q < DEPTH_C);
    assign pop      = eng_ready && (inflight_q != '0);
    assign last_pos = (ox_q == OW_LAST) && (oy_q == OH_LAST);

    // Window origin, tap mask and write address for the current position
    always_comb begin
        row_i  = int'(oy_q) * STRIDE - PAD;
        col_i  = int'(ox_q) * STRIDE - PAD;
        row_d  = COORD_W'(row_i);
        col_d  = COORD_W'(col_i);
        addr_d = ADDR_W'(int'(oy_q) * OW + int'(ox_q));
        mask_d = '0;
        for (int unsigned k = 0; k < 9; k++) begin
            mask_d[k] = (row_i + int'(k / 3) >= 0) && (row_i + int'(k / 3) < IMG_H) &&
                        (col_i + int'(k % 3) >= 0) && (col_i + int'(k % 3) < IMG_W);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_RUN;
            S_RUN:   if (issue && last_pos) state_d = S_DRAIN;
            // A pop of the final entry in this cycle also empties the FIFO
            S_DRAIN: if (inflight_q == '0 || (inflight_q == ONE_C && pop)) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ox_q       <= '0;
            oy_q       <= '0;
            eng_valid  <= 1'b0;
            win_row    <= '0;
            win_col    <= '0;
            tap_mask   <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            inflight_q <= '0;
            err        <= 1'b0;
        end else begin
            eng_valid <= issue;
            if (issue) begin
                win_row  <= row_d;
                win_col  <= col_d;
                tap_mask <= mask_d;
                wr_ptr_q <= wr_ptr_q + 1'b1;
                if (last_pos) begin
                    ox_q <= '0;
                    oy_q <= '0;
                end else if (ox_q == OW_LAST) begin
                    ox_q <= '0;
                    oy_q <= oy_q + 1'b1;
                end else begin
                    ox_q <= ox_q + 1'b1;
                end
            end
            if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({issue, pop})
                2'b10:   inflight_q <= inflight_q + 1'b1;
                2'b01:   inflight_q <= inflight_q - 1'b1;
                default: inflight_q <= inflight_q;
            endcase
            if (eng_ready && inflight_q == '0) err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (issue) tag_mem[wr_ptr_q] <= addr_d;
    end

    assign out_wr_en   = pop;
    assign out_wr_addr = pop ? tag_mem[rd_ptr_q] : '0;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_dw_sched.sv
// Directed bench for conv_dw_sched on a 4x4 map: three stride/pad configurations with a 1-cycle engine model.
module tb_conv_dw_sched;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic hold = 1'b0;
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // a: PAD=1 STRIDE=1, b: PAD=0 STRIDE=2, c: PAD=1 STRIDE=2
    logic              start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
    logic              eng_ready_a = 1'b0, eng_ready_b = 1'b0, eng_ready_c = 1'b0;
    logic              eng_valid_a, eng_valid_b, eng_valid_c;
    logic signed [7:0] win_row_a, win_row_b, win_row_c, win_col_a, win_col_b, win_col_c;
    logic [8:0]        tap_mask_a, tap_mask_b, tap_mask_c;
    logic              out_wr_en_a, out_wr_en_b, out_wr_en_c;
    logic [9:0]        out_wr_addr_a, out_wr_addr_b, out_wr_addr_c;
    logic              busy_a, busy_b, busy_c, done_a, done_b, done_c, err_a, err_b, err_c;

    conv_dw_sched #(.IMG_H(4), .IMG_W(4), .STRIDE(1), .PAD(1), .COORD_W(8), .ADDR_W(10), .TAG_DEPTH(4)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .hold(hold), .eng_valid(eng_valid_a),
        .win_row(win_row_a), .win_col(win_col_a), .tap_mask(tap_mask_a), .eng_ready(eng_ready_a),
        .out_wr_en(out_wr_en_a), .out_wr_addr(out_wr_addr_a), .busy(busy_a), .done(done_a), .err(err_a));

    conv_dw_sched #(.IMG_H(4), .IMG_W(4), .STRIDE(2), .PAD(0), .COORD_W(8), .ADDR_W(10), .TAG_DEPTH(4)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .hold(1'b0), .eng_valid(eng_valid_b),
        .win_row(win_row_b), .win_col(win_col_b), .tap_mask(tap_mask_b), .eng_ready(eng_ready_b),
        .out_wr_en(out_wr_en_b), .out_wr_addr(out_wr_addr_b), .busy(busy_b), .done(done_b), .err(err_b));

    conv_dw_sched #(.IMG_H(4), .IMG_W(4), .STRIDE(2), .PAD(1), .COORD_W(8), .ADDR_W(10), .TAG_DEPTH(4)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .hold(1'b0), .eng_valid(eng_valid_c),
        .win_row(win_row_c), .win_col(win_col_c), .tap_mask(tap_mask_c), .eng_ready(eng_ready_c),
        .out_wr_en(out_wr_en_c), .out_wr_addr(out_wr_addr_c), .busy(busy_c), .done(done_c), .err(err_c));

    // 1-cycle engine: result returns the cycle after the window is issued; not reset on purpose
    always @(posedge clk) begin
        eng_ready_a <= eng_valid_a;
        eng_ready_b <= eng_valid_b;
        eng_ready_c <= eng_valid_c;
    end

    // Issue record = {row, col, mask}
    logic [24:0] iss_a[$], iss_b[$], iss_c[$];
    int          iss_cyc_a[$];
    logic [9:0]  wr_a[$], wr_b[$], wr_c[$];
    int          wr_cyc_a[$], wr_cyc_b[$];
    int          done_n_a = 0, done_n_b = 0, done_n_c = 0;
    int          done_cyc_a = 0, done_cyc_b = 0;

    always @(posedge clk) begin
        #1;
        if (eng_valid_a) begin
            iss_a.push_back({win_row_a, win_col_a, tap_mask_a});
            iss_cyc_a.push_back(cyc);
        end
        if (out_wr_en_a) begin
            wr_a.push_back(out_wr_addr_a);
            wr_cyc_a.push_back(cyc);
        end
        if (done_a) begin
            done_n_a++;
            done_cyc_a = cyc;
        end
        if (eng_valid_b) iss_b.push_back({win_row_b, win_col_b, tap_mask_b});
        if (out_wr_en_b) begin
            wr_b.push_back(out_wr_addr_b);
            wr_cyc_b.push_back(cyc);
        end
        if (done_b) begin
            done_n_b++;
            done_cyc_b = cyc;
        end
        if (eng_valid_c) iss_c.push_back({win_row_c, win_col_c, tap_mask_c});
        if (out_wr_en_c) wr_c.push_back(out_wr_addr_c);
        if (done_c) done_n_c++;
    end

    task automatic clear_a();
        iss_a.delete();
        iss_cyc_a.delete();
        wr_a.delete();
        wr_cyc_a.delete();
        done_n_a = 0;
    endtask

    task automatic start_pass_a();
        clear_a();
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({busy_a, done_a, eng_valid_a, out_wr_en_a, err_a} !== 5'b0)
            begin n_fail++; $display("FAIL reset_flags: got %b want 00000", {busy_a, done_a, eng_valid_a, out_wr_en_a, err_a}); end
        n_tests++;
        if ({win_row_a, win_col_a, tap_mask_a, out_wr_addr_a} !== 35'h0)
            begin n_fail++; $display("FAIL reset_outputs: got %h want 0", {win_row_a, win_col_a, tap_mask_a, out_wr_addr_a}); end
        n_tests++;
        if ({busy_b, busy_c, err_b, err_c} !== 4'b0)
            begin n_fail++; $display("FAIL reset_bc: got %b want 0000", {busy_b, busy_c, err_b, err_c}); end
    endtask

    task automatic test_raster();
        logic [15:0] exp_rc;
        start_pass_a();
        for (int i = 0; i < 200 && done_n_a == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_tests++;
        if (done_n_a != 1) begin n_fail++; $display("FAIL t1_done_count: got %0d want 1", done_n_a); end
        n_tests++;
        if (iss_a.size() != 16) begin n_fail++; $display("FAIL t1_issue_count: got %0d want 16", iss_a.size()); end
        n_tests++;
        if (iss_a[0] !== {8'hFF, 8'hFF, 9'b110_110_000})
            begin n_fail++; $display("FAIL t1_first_issue: got %h want %h", iss_a[0], {8'hFF, 8'hFF, 9'b110_110_000}); end
        n_tests++;
        if (iss_a[5] !== {8'd0, 8'd0, 9'h1FF})
            begin n_fail++; $display("FAIL t1_interior_issue: got %h want %h", iss_a[5], {8'd0, 8'd0, 9'h1FF}); end
        n_tests++;
        if (iss_a[15] !== {8'd2, 8'd2, 9'b000_011_011})
            begin n_fail++; $display("FAIL t1_last_issue: got %h want %h", iss_a[15], {8'd2, 8'd2, 9'b000_011_011}); end
        for (int i = 0; i < 16; i++) begin
            exp_rc = {8'(i / 4 - 1), 8'(i % 4 - 1)};
            n_tests++;
            if (iss_a[i][24:9] !== exp_rc)
                begin n_fail++; $display("FAIL t1_origin[%0d]: got %h want %h", i, iss_a[i][24:9], exp_rc); end
        end
        n_tests++;
        if (iss_cyc_a[15] - iss_cyc_a[0] != 15)
            begin n_fail++; $display("FAIL t1_issue_span: got %0d want 15", iss_cyc_a[15] - iss_cyc_a[0]); end
        n_tests++;
        if (wr_a.size() != 16) begin n_fail++; $display("FAIL t1_write_count: got %0d want 16", wr_a.size()); end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (wr_a[i] !== 10'(i)) begin n_fail++; $display("FAIL t1_addr[%0d]: got %0d want %0d", i, wr_a[i], i); end
        end
        n_tests++;
        if (done_cyc_a != wr_cyc_a[15] + 1)
            begin n_fail++; $display("FAIL t1_done_timing: got cycle %0d want %0d", done_cyc_a, wr_cyc_a[15] + 1); end
        n_tests++;
        if ({busy_a, err_a} !== 2'b00) begin n_fail++; $display("FAIL t1_idle_after: got %b want 00", {busy_a, err_a}); end
    endtask

    task automatic test_single_window();
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        for (int i = 0; i < 50 && done_n_b == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_tests++;
        if (iss_b.size() != 1 || iss_b[0] !== {8'd0, 8'd0, 9'h1FF})
            begin n_fail++; $display("FAIL t2_issue: got n=%0d %h want n=1 %h", iss_b.size(), iss_b[0], {8'd0, 8'd0, 9'h1FF}); end
        n_tests++;
        if (wr_b.size() != 1 || wr_b[0] !== 10'd0)
            begin n_fail++; $display("FAIL t2_write: got n=%0d addr=%0d want n=1 addr=0", wr_b.size(), wr_b[0]); end
        n_tests++;
        if (done_n_b != 1 || done_cyc_b != wr_cyc_b[0] + 1)
            begin n_fail++; $display("FAIL t2_done: got n=%0d cyc=%0d want n=1 cyc=%0d", done_n_b, done_cyc_b, wr_cyc_b[0] + 1); end
    endtask

    task automatic test_stride2_pad1();
        logic [24:0] exp_iss [4];
        exp_iss[0] = {8'hFF, 8'hFF, 9'h1B0};
        exp_iss[1] = {8'hFF, 8'h01, 9'h1F8};
        exp_iss[2] = {8'h01, 8'hFF, 9'h1B6};
        exp_iss[3] = {8'h01, 8'h01, 9'h1FF};
        start_c = 1'b1;
        @(negedge clk);
        start_c = 1'b0;
        for (int i = 0; i < 50 && done_n_c == 0; i++) @(negedge clk);
        repeat (2) @(negedge clk);
        n_tests++;
        if (iss_c.size() != 4 || wr_c.size() != 4 || done_n_c != 1)
            begin n_fail++; $display("FAIL t3_counts: got iss=%0d wr=%0d done=%0d want 4 4 1", iss_c.size(), wr_c.size(), done_n_c); end
        for (int i = 0; i < 4; i++) begin
            n_tests++;
            if (iss_c[i] !== exp_iss[i] || wr_c[i] !== 10'(i))
                begin n_fail++; $display("FAIL t3_window[%0d]: got %h/%0d want %h/%0d", i, iss_c[i], wr_c[i], exp_iss[i], i); end
        end
    endtask

    task automatic test_hold();
        start_pass_a();
        repeat (2) @(negedge clk);
        hold = 1'b1;
        repeat (3) @(negedge clk);
        hold = 1'b0;
        for (int i = 0; i < 200 && done_n_a == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_tests++;
        if (iss_a.size() != 16 || done_n_a != 1)
            begin n_fail++; $display("FAIL t4_counts: got iss=%0d done=%0d want 16 1", iss_a.size(), done_n_a); end
        n_tests++;
        if (iss_cyc_a[2] - iss_cyc_a[1] != 4)
            begin n_fail++; $display("FAIL t4_gap: got %0d want 4", iss_cyc_a[2] - iss_cyc_a[1]); end
        n_tests++;
        if (iss_cyc_a[15] - iss_cyc_a[0] != 18)
            begin n_fail++; $display("FAIL t4_span: got %0d want 18", iss_cyc_a[15] - iss_cyc_a[0]); end
        n_tests++;
        if (iss_a[2][24:9] !== {8'hFF, 8'h01})
            begin n_fail++; $display("FAIL t4_resume_pos: got %h want ff01", iss_a[2][24:9]); end
        n_tests++;
        if (wr_a.size() != 16) begin n_fail++; $display("FAIL t4_write_count: got %0d want 16", wr_a.size()); end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (wr_a[i] !== 10'(i)) begin n_fail++; $display("FAIL t4_addr[%0d]: got %0d want %0d", i, wr_a[i], i); end
        end
    endtask

    task automatic test_start_while_busy();
        start_pass_a();
        for (int i = 0; i < 50 && iss_a.size() < 5; i++) @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int i = 0; i < 200 && done_n_a == 0; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        n_tests++;
        if (iss_a.size() != 16 || wr_a.size() != 16 || done_n_a != 1)
            begin n_fail++; $display("FAIL t5_counts: got iss=%0d wr=%0d done=%0d want 16 16 1", iss_a.size(), wr_a.size(), done_n_a); end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (wr_a[i] !== 10'(i)) begin n_fail++; $display("FAIL t5_addr[%0d]: got %0d want %0d", i, wr_a[i], i); end
        end
        n_tests++;
        if ({busy_a, err_a} !== 2'b00) begin n_fail++; $display("FAIL t5_idle_after: got %b want 00", {busy_a, err_a}); end
    endtask

    task automatic test_reset_midpass();
        start_pass_a();
        for (int i = 0; i < 50 && iss_a.size() < 7; i++) @(negedge clk);
        n_tests++;
        if (iss_a.size() != 7) begin n_fail++; $display("FAIL t6_reach_issue7: got %0d want 7", iss_a.size()); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_tests++;
        if ({busy_a, err_a} !== 2'b00) begin n_fail++; $display("FAIL t6_after_rst: got %b want 00", {busy_a, err_a}); end
        @(negedge clk);
        n_tests++;
        if (err_a !== 1'b1) begin n_fail++; $display("FAIL t6_stale_err: got %b want 1", err_a); end
        repeat (3) @(negedge clk);
        n_tests++;
        if (done_n_a != 0) begin n_fail++; $display("FAIL t6_no_done: got %0d want 0", done_n_a); end
        start_pass_a();
        for (int i = 0; i < 200 && done_n_a == 0; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        n_tests++;
        if (wr_a.size() != 16 || done_n_a != 1)
            begin n_fail++; $display("FAIL t6_repass_counts: got wr=%0d done=%0d want 16 1", wr_a.size(), done_n_a); end
        for (int i = 0; i < 16; i++) begin
            n_tests++;
            if (wr_a[i] !== 10'(i)) begin n_fail++; $display("FAIL t6_addr[%0d]: got %0d want %0d", i, wr_a[i], i); end
        end
        n_tests++;
        if ({busy_a, err_a} !== 2'b01) begin n_fail++; $display("FAIL t6_err_sticky: got %b want 01", {busy_a, err_a}); end
    endtask

    initial begin
        test_reset();
        test_raster();
        test_single_window();
        test_stride2_pad1();
        test_hold();
        test_start_while_busy();
        test_reset_midpass();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
